// File: rtl/comp_ctrl_pkg.sv
// Shared pixel-size encodings and phrase geometry helpers for the compare/inhibit controller.
package comp_ctrl_pkg;

  localparam logic [2:0] PIX_8  = 3'd3;
  localparam logic [2:0] PIX_16 = 3'd4;
  localparam logic [2:0] PIX_32 = 3'd5;

  // Pixels per phrase for any encoded size; undefined encodings give zero.
  function automatic int pix_per_phrase(input logic [2:0] pixsize, input int lanes);
    if (pixsize > PIX_32) return 0;
    return (lanes * 8) >> pixsize;
  endfunction

  function automatic int lanes_per_pix(input logic [2:0] pixsize);
    case (pixsize)
      PIX_16:  return 2;
      PIX_32:  return 4;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/comp_bitsel.sv
// Selects one srcd bit per pixel slot, walking from the effective bit pointer.
module comp_bitsel #(
  parameter  int LANES = 8,
  parameter  int SRCW  = 8,
  localparam int PW    = $clog2(SRCW)
) (
  input  logic [SRCW-1:0]  srcd,
  input  logic [PW-1:0]    bitptr_eff,
  input  logic             big_pix,
  output logic [LANES-1:0] bit_set
);

  for (genvar k = 0; k < LANES; k++) begin : g_pix
    logic [PW-1:0] idx;
    logic [PW-1:0] idx_ord;
    assign idx     = bitptr_eff + PW'(k);
    // SRCW is a power of two, so SRCW-1-idx is a plain bit inversion.
    assign idx_ord = big_pix ? ~idx : idx;
    assign bit_set[k] = srcd[idx_ord];
  end

endmodule

// File: rtl/comp_ctrl_gen.sv
// Registered compare/inhibit controller: captures a step, combines data/Z/bit compares
// into per-lane write inhibits and a whole-write suppress, and walks the srcd bit pointer.
module comp_ctrl_gen
  import comp_ctrl_pkg::*;
#(
  parameter  int LANES  = 8,
  parameter  int ZLANES = LANES / 2,
  parameter  int SRCW   = 8,
  localparam int PW     = $clog2(SRCW)
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              step_inner,
  input  logic              phrase_mode,
  input  logic [2:0]        pixsize,
  input  logic              dcompen,
  input  logic              zcomp_en,
  input  logic              bcompen,
  input  logic              bkgwren,
  input  logic              big_pix,
  input  logic [LANES-1:0]  dcomp,
  input  logic [ZLANES-1:0] zcomp,
  input  logic [SRCW-1:0]   srcd,
  input  logic              bit_load,
  input  logic [PW-1:0]     bit_start,
  output logic [LANES-1:0]  dbinh_n,
  output logic              nowrite,
  output logic              out_valid,
  output logic [PW-1:0]     bitptr
);

  logic              q_step, q_phrase, q_dcompen, q_zcomp_en, q_bcompen, q_bkgwren;
  logic              q_big_pix, q_bit_load;
  logic [2:0]        q_pixsize;
  logic [LANES-1:0]  q_dcomp;
  logic [ZLANES-1:0] q_zcomp;
  logic [SRCW-1:0]   q_srcd;
  logic [PW-1:0]     q_bit_start;

  logic [PW-1:0]     bitptr_eff, step_adv, bitptr_next;
  logic [LANES-1:0]  bit_set, pix_inh, lane_inh;
  logic              bc_en;

  // Input capture stage: outputs appear one edge after the step is sampled.
  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      q_step      <= 1'b0;
      q_phrase    <= 1'b0;
      q_pixsize   <= '0;
      q_dcompen   <= 1'b0;
      q_zcomp_en  <= 1'b0;
      q_bcompen   <= 1'b0;
      q_bkgwren   <= 1'b0;
      q_big_pix   <= 1'b0;
      q_dcomp     <= '0;
      q_zcomp     <= '0;
      q_srcd      <= '0;
      q_bit_load  <= 1'b0;
      q_bit_start <= '0;
    end else begin
      q_step      <= step_inner;
      q_phrase    <= phrase_mode;
      q_pixsize   <= pixsize;
      q_dcompen   <= dcompen;
      q_zcomp_en  <= zcomp_en;
      q_bcompen   <= bcompen;
      q_bkgwren   <= bkgwren;
      q_big_pix   <= big_pix;
      q_dcomp     <= dcomp;
      q_zcomp     <= zcomp;
      q_srcd      <= srcd;
      q_bit_load  <= bit_load;
      q_bit_start <= bit_start;
    end
  end

  assign bitptr_eff = (q_step && q_bit_load) ? q_bit_start : bitptr;

  comp_bitsel #(.LANES(LANES), .SRCW(SRCW)) u_bitsel (
    .srcd       (q_srcd),
    .bitptr_eff (bitptr_eff),
    .big_pix    (q_big_pix),
    .bit_set    (bit_set)
  );

  // NOTE: every variable is defaulted first so no path through the case infers a latch.
  always_comb begin
    pix_inh  = '0;
    lane_inh = '0;
    bc_en    = q_bcompen & ~q_bkgwren;
    case (q_pixsize)
      PIX_8: begin
        for (int k = 0; k < LANES; k++) begin
          pix_inh[k]  = (q_dcompen & q_dcomp[k]) | (bc_en & ~bit_set[k]);
          lane_inh[k] = pix_inh[k];
        end
      end
      PIX_16: begin
        for (int k = 0; k < LANES / 2; k++) begin
          pix_inh[k] = (q_dcompen & (&q_dcomp[2*k +: 2])) | (q_zcomp_en & q_zcomp[k])
                     | (bc_en & ~bit_set[k]);
          lane_inh[2*k +: 2] = {2{pix_inh[k]}};
        end
      end
      PIX_32: begin
        for (int k = 0; k < LANES / 4; k++) begin
          pix_inh[k] = (q_dcompen & (&q_dcomp[4*k +: 4])) | (bc_en & ~bit_set[k]);
          lane_inh[4*k +: 4] = {4{pix_inh[k]}};
        end
      end
      default: ;
    endcase
    step_adv    = q_phrase ? PW'(pix_per_phrase(q_pixsize, LANES)) : PW'(1);
    bitptr_next = bitptr_eff + step_adv;
  end

  // NOTE: only control/output flops need reset values; nothing here is a memory array.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      dbinh_n   <= '1;
      nowrite   <= 1'b0;
      out_valid <= 1'b0;
      bitptr    <= '0;
    end else begin
      out_valid <= q_step;
      if (q_step) begin
        dbinh_n <= q_phrase ? ~lane_inh : '1;
        nowrite <= q_phrase ? (&lane_inh) : pix_inh[0];
        bitptr  <= bitptr_next;
      end else if (q_bit_load) begin
        bitptr  <= q_bit_start;
      end
    end
  end

endmodule

// File: doc/comp_ctrl_gen.md
Name: comp_ctrl_gen

Overview:
- Parametrised, registered successor to the blitter compare/inhibit controller.
- Per inner-loop step it combines data compare, Z compare and bit-compare (srcd expansion) results into per-byte-lane write inhibits for one phrase, plus a whole-write suppress.
- New behaviour versus the previous generation:
  - a bit-pointer counter that walks the srcd byte across successive steps, with preload and big_pix bit reversal;
  - LANES-wide phrases;
  - registered outputs with a valid strobe.
- Sits between the blitter data path compare units and the write-strobe generator.

Parameters:
- LANES, 8, byte lanes per phrase (power of two, >=4).
- ZLANES, LANES/2, Z-compare flags (one per 16-bit lane pair).
- SRCW, 8, srcd bit-compare source width (power of two); PW = log2(SRCW).

Ports:
- sys_clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- step_inner  in  1  one-cycle strobe; evaluate the current phrase/pixel
- phrase_mode  in  1  1 = phrase write, 0 = single-pixel write
- pixsize  in  3  0..5 = 1,2,4,8,16,32 bpp
- dcompen  in  1  enable data-compare inhibit
- zcomp_en  in  1  enable Z-compare inhibit
- bcompen  in  1  enable bit-compare inhibit
- bkgwren  in  1  background write enable; disables bit-compare inhibit
- big_pix  in  1  big-endian pixel order for bit-compare
- dcomp  in  LANES  per-byte data-compare-equal flags
- zcomp  in  ZLANES  per-pair Z-fail flags
- srcd  in  SRCW  bit-compare source byte
- bit_load  in  1  preload bit pointer
- bit_start  in  PW  preload value
- dbinh_n  out  LANES  byte-lane write inhibit, active low
- nowrite  out  1  suppress entire write
- out_valid  out  1  one-cycle pulse; outputs updated
- bitptr  out  PW  current bit pointer, for debug

Behaviour:
- Reset (asynchronous, any time, including mid-operation): dbinh_n = all ones, nowrite = 0, out_valid = 0, bitptr = 0. Take effect immediately.
- Timing and hold:
  - All outputs register on sys_clk.
  - step_inner sampled at edge N gives updated outputs and out_valid = 1 after edge N+1.
  - With no step_inner, outputs hold and out_valid = 0.
- Pixel grouping: pixels per phrase P = LANES, LANES/2, LANES/4 for 8/16/32 bpp. Pixel k owns byte lanes [k*B, k*B+B-1], where B = 1, 2, 4.
- Inhibit for pixel k is the OR of the following terms:
  - Data-compare term (dcompen): AND of dcomp over pixel k's lanes.
  - Z-compare term (zcomp_en): 16 bpp only, zcomp[k]. Ignored for other sizes.
  - Bit-compare term (bcompen & !bkgwren): NOT srcd[idx].
    - idx = (bitptr_eff + k) mod SRCW.
    - If big_pix, idx becomes SRCW-1-idx.
- pixsize < 3 (sub-byte) or > 5: no inhibit terms apply; dbinh_n = all ones, nowrite = 0.
- Effective pointer: bitptr_eff = bit_start if bit_load is asserted in the same cycle as step_inner, else bitptr.
- Phrase mode:
  - Per-lane inhibit drives dbinh_n (0 = inhibited).
  - nowrite = 1 iff every lane is inhibited.
  - bitptr updates to (bitptr_eff + P) mod SRCW.
- Pixel mode:
  - Evaluate pixel 0 only, at idx = bitptr_eff.
  - dbinh_n = all ones; nowrite = pixel-0 inhibit.
  - bitptr updates to (bitptr_eff + 1) mod SRCW.
- bit_load without step_inner: bitptr = bit_start; other outputs unchanged.
- Pointer arithmetic is PW bits and wraps silently. bitptr advances on every step, whether or not bcompen is set.

Decomposition:
- Shared package comp_ctrl_pkg holds:
  - pixsize encodings PIX_8/PIX_16/PIX_32 (3, 4, 5);
  - function pix_per_phrase(pixsize, LANES);
  - function lanes_per_pix(pixsize).
- One sub-module, comp_bitsel: combinational srcd bit selector producing P bit-compare results from srcd, bitptr_eff and big_pix.
- Lane combine, registers and pointer logic stay in the top module.

Test Plan (LANES = 8, SRCW = 8):
- 8 bpp phrase, dcompen, dcomp = 8'b00000101, step -> next cycle dbinh_n = 8'b11111010, nowrite = 0, out_valid pulse for 1 cycle.
- 16 bpp phrase, zcomp_en, zcomp = 4'b0010 -> dbinh_n = 8'b11110011. Then 32 bpp, dcompen, dcomp = 8'hF0 -> dbinh_n = 8'h0F. Then dcomp = 8'hFF -> dbinh_n = 8'h00, nowrite = 1.
- Bit-compare, 16 bpp phrase, bit_load with bit_start = 0 plus step:
  - srcd = 8'h0F -> dbinh_n = 8'hFF, bitptr = 4;
  - second step -> dbinh_n = 8'h00, nowrite = 1, bitptr = 0 (wrap).
- 8 bpp phrase, srcd = 8'hAA: big_pix = 0 -> dbinh_n = 8'hAA; big_pix = 1 -> dbinh_n = 8'h55. With bkgwren = 1 -> dbinh_n = 8'hFF.
- Pixel mode, bitptr = 7, srcd = 8'h7F, bcompen, step -> nowrite = 1, dbinh_n = 8'hFF, bitptr = 0. Next step -> nowrite = 0.
- Assert reset between step_inner and the following edge -> outputs stay at reset values, no out_valid, bitptr = 0. Then bit_load = 5 alone -> bitptr = 5, out_valid = 0.
